// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring shift-subtract divide on operand magnitudes.
// Sign and exception are applied in a final fix-up cycle. Latency is fixed at LATENCY
// edges from the accepting edge to data_resultRDY.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous, active-high reset
//   data_operandA  - multiplicand / dividend (two's complement)
//   data_operandB  - multiplier / divisor (two's complement)
//   ctrl_MULT      - start multiply (accepted in IDLE/DONE when ctrl_DIV is low)
//   ctrl_DIV       - start divide (accepted in IDLE/DONE when ctrl_MULT is low)
//   data_result    - product low word / quotient, held until the next completion
//   data_exception - overflow / divide-by-zero flag, qualified by data_resultRDY
//   data_resultRDY - one-cycle completion pulse
//   busy           - high while an operation is in flight
module multdiv_sequencer #(
   parameter  int unsigned DATA_WIDTH = 32,
   localparam int unsigned LATENCY    = DATA_WIDTH + 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_operandA,
   input  logic [DATA_WIDTH-1:0] data_operandB,
   input  logic                  ctrl_MULT,
   input  logic                  ctrl_DIV,
   output logic [DATA_WIDTH-1:0] data_result,
   output logic                  data_exception,
   output logic                  data_resultRDY,
   output logic                  busy
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);
   // Iterations end three edges before completion: load cycle, FIX, DONE.
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 3);
   localparam logic [W-1:0]  ONE_W    = W'(1);
   localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t          r_state, w_state_next;
   logic [W-1:0]    r_opa, r_opb;
   logic            r_is_div;
   logic            r_load;     // first RUN cycle prepares magnitudes
   logic [CW-1:0]   r_cnt;
   logic [2*W-1:0]  r_acc;      // mult: {hi, multiplier/lo}; div: low half holds dividend/quotient
   logic [W-1:0]    r_rem;
   logic [W-1:0]    r_mcand;    // |A| for multiply, |B| for divide
   logic [W-1:0]    r_result;
   logic            r_exc;

   logic            w_start;
   logic [W-1:0]    w_mag_a, w_mag_b;
   logic [W:0]      w_sum;
   logic [2*W:0]    w_mul_wide;
   logic [W:0]      w_shift, w_diff;
   logic            w_qbit;
   logic [W-1:0]    w_rem_next;
   logic            w_neg;
   logic [2*W-1:0]  w_prod;
   logic [W-1:0]    w_quo;
   logic [W-1:0]    w_fix_result;
   logic            w_fix_exc;

   assign w_start = (ctrl_MULT ^ ctrl_DIV) && ((r_state == IDLE) || (r_state == DONE));

   // |MIN_NEG| wraps to itself, which is the correct unsigned magnitude.
   assign w_mag_a = r_opa[W-1] ? (~r_opa + ONE_W) : r_opa;
   assign w_mag_b = r_opb[W-1] ? (~r_opb + ONE_W) : r_opb;

   // Multiply step: conditional add into the high word, then shift right with carry.
   assign w_sum      = r_acc[0] ? ({1'b0, r_acc[2*W-1:W]} + {1'b0, r_mcand})
                                : {1'b0, r_acc[2*W-1:W]};
   assign w_mul_wide = {w_sum, r_acc[W-1:0]};

   // Divide step: shift in the next dividend bit, trial-subtract, restore if negative.
   assign w_shift    = {r_rem, r_acc[W-1]};
   assign w_diff     = w_shift - {1'b0, r_mcand};
   assign w_qbit     = ~w_diff[W];
   assign w_rem_next = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];

   // Sign fix-up and exception detection.
   assign w_neg  = r_opa[W-1] ^ r_opb[W-1];
   assign w_prod = w_neg ? (~r_acc + {{W{1'b0}}, ONE_W}) : r_acc;
   assign w_quo  = w_neg ? (~r_acc[W-1:0] + ONE_W) : r_acc[W-1:0];

   always_comb begin
      w_fix_result = w_prod[W-1:0];
      w_fix_exc    = (w_prod[2*W-1:W] != {W{w_prod[W-1]}});
      if (r_is_div) begin
         w_fix_result = w_quo;
         w_fix_exc    = 1'b0;
         if (r_opb == '0) begin
            w_fix_result = '0;
            w_fix_exc    = 1'b1;
         end else if ((r_opa == MIN_NEG) && (r_opb == {W{1'b1}})) begin
            w_fix_exc    = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_start) w_state_next = RUN;
         RUN:     if (!r_load && (r_cnt == CNT_LAST)) w_state_next = FIX;
         FIX:     w_state_next = DONE;
         DONE:    w_state_next = w_start ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_is_div <= 1'b0;
         r_load   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_mcand  <= '0;
         r_result <= '0;
         r_exc    <= 1'b0;
      end else if (w_start) begin
         r_opa    <= data_operandA;
         r_opb    <= data_operandB;
         r_is_div <= ctrl_DIV;
         r_load   <= 1'b1;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         if (r_load) begin
            r_load  <= 1'b0;
            r_rem   <= '0;
            r_acc   <= {{W{1'b0}}, (r_is_div ? w_mag_a : w_mag_b)};
            r_mcand <= r_is_div ? w_mag_b : w_mag_a;
         end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
               r_rem          <= w_rem_next;
               r_acc[W-1:0]   <= {r_acc[W-2:0], w_qbit};
            end else begin
               r_acc <= w_mul_wide[2*W:1];
            end
         end
      end else if (r_state == FIX) begin
         r_result <= w_fix_result;
         r_exc    <= w_fix_exc;
      end
   end

   assign data_result    = r_result;
   assign data_resultRDY = (r_state == DONE);
   assign data_exception = r_exc & (r_state == DONE);
   assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed self-checking bench for multdiv_sequencer.
// Table of multiply/divide vectors plus hand-written sequences for ignored starts,
// back-to-back issue and reset abort.
module tb_multdiv_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;

   int tests_run = 0;
   int tests_failed = 0;

   multdiv_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive a start for one edge; returns #1 after the accepting edge.
   task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = !is_div;
      ctrl_DIV      = is_div;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h1234_5678;
   endtask

   // Count edges until RDY (bounded); track busy staying high and exception staying low.
   task automatic wait_rdy(output int edges, output bit busy_ok, output bit exc_ok);
      edges   = -1;
      busy_ok = 1'b1;
      exc_ok  = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clock);
         #1;
         if (!busy) busy_ok = 1'b0;
         if (data_resultRDY) begin
            edges = i;
            return;
         end
         if (data_exception) exc_ok = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int edges;
      bit busy_ok, exc_ok;
      start_op(v.is_div, v.a, v.b);
      chk({v.name, " busy_after_accept"}, {31'd0, busy}, 32'd1);
      wait_rdy(edges, busy_ok, exc_ok);
      chk({v.name, " latency"}, edges, 32'd34);
      chk({v.name, " result"}, data_result, v.res);
      chk({v.name, " exception"}, {31'd0, data_exception}, {31'd0, v.exc});
      chk({v.name, " busy_steady"}, {31'd0, busy_ok}, 32'd1);
      chk({v.name, " exc_low_before_rdy"}, {31'd0, exc_ok}, 32'd1);
      @(posedge clock);
      #1;
      chk({v.name, " rdy_falls"}, {31'd0, data_resultRDY}, 32'd0);
      chk({v.name, " exc_falls"}, {31'd0, data_exception}, 32'd0);
      chk({v.name, " busy_falls"}, {31'd0, busy}, 32'd0);
      chk({v.name, " result_held"}, data_result, v.res);
   endtask

   initial begin
      int  edges;
      bit  busy_ok, exc_ok;
      bit  saw_rdy, saw_busy;

      vecs[0]  = '{"mul_7_m6",        1'b0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      vecs[1]  = '{"mul_ovf_2p32",    1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{"mul_min_x1",      1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
      vecs[3]  = '{"mul_m3_m5",       1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,        1'b0};
      vecs[4]  = '{"mul_max_x2",      1'b0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1};
      vecs[5]  = '{"mul_0_m5",        1'b0, 32'd0,         32'hFFFF_FFFB, 32'd0,         1'b0};
      vecs[6]  = '{"div_m7_2",        1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      vecs[7]  = '{"div_100_0",       1'b1, 32'd100,       32'd0,         32'd0,         1'b1};
      vecs[8]  = '{"div_min_m1",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[9]  = '{"div_min_2",       1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};
      vecs[10] = '{"div_100_7",       1'b1, 32'd100,       32'd7,         32'd14,        1'b0};
      vecs[11] = '{"div_7_m100",      1'b1, 32'd7,         32'hFFFF_FF9C, 32'd0,         1'b0};

      reset = 1'b1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      @(posedge clock);
      // A start on a reset edge must be ignored.
      #1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd3;
      data_operandB = 32'd4;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      chk("reset result", data_result, 32'd0);
      chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      chk("reset exc", {31'd0, data_exception}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("start_on_reset_ignored", {31'd0, busy}, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Mult 3x5 with a stray DIV at cycle 10 and both starts at cycle 20.
      start_op(1'b0, 32'd3, 32'd5);
      edges = -1;
      busy_ok = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         ctrl_DIV      = (e == 10) || (e == 20);
         ctrl_MULT     = (e == 20);
         data_operandA = (e == 10 || e == 20) ? 32'd100 : 32'hDEAD_BEEF;
         data_operandB = (e == 10 || e == 20) ? 32'd9   : 32'h1234_5678;
         @(posedge clock);
         #1;
         ctrl_DIV  = 1'b0;
         ctrl_MULT = 1'b0;
         if (!busy) busy_ok = 1'b0;
         if (data_resultRDY) begin
            edges = e;
            break;
         end
      end
      chk("ignored_starts latency", edges, 32'd34);
      chk("ignored_starts result", data_result, 32'd15);
      chk("ignored_starts exc", {31'd0, data_exception}, 32'd0);
      chk("ignored_starts busy", {31'd0, busy_ok}, 32'd1);

      // Back-to-back: new MULT accepted on the edge that ends the RDY cycle.
      start_op(1'b0, 32'd6, 32'd7);
      chk("b2b busy_no_gap", {31'd0, busy}, 32'd1);
      chk("b2b rdy_low", {31'd0, data_resultRDY}, 32'd0);
      chk("b2b old_result_held", data_result, 32'd15);
      wait_rdy(edges, busy_ok, exc_ok);
      chk("b2b latency", edges, 32'd34);
      chk("b2b result", data_result, 32'd42);
      chk("b2b busy_steady", {31'd0, busy_ok}, 32'd1);

      // Div aborted by reset at cycle 12, with a start on the reset edge.
      @(posedge clock);
      #1;
      start_op(1'b1, 32'd100, 32'd7);
      repeat (11) @(posedge clock);
      #1;
      reset = 1'b1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd2;
      data_operandB = 32'd2;
      @(posedge clock);
      #1;
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      chk("abort result", data_result, 32'd0);
      chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
      chk("abort exc", {31'd0, data_exception}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      saw_rdy = 1'b0;
      saw_busy = 1'b0;
      for (int e = 0; e < 50; e++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) saw_rdy = 1'b1;
         if (busy) saw_busy = 1'b1;
      end
      chk("abort no_rdy", {31'd0, saw_rdy}, 32'd0);
      chk("abort idle", {31'd0, saw_busy}, 32'd0);

      run_vec(vecs[0]);
      run_vec(vecs[6]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
